// File: rtl/led_strip_driver_pkg.sv
// led_strip_driver_pkg: shared serial LED timing defaults (50 MHz clock) and driver state type.
package led_strip_driver_pkg;
  localparam int T_BIT_50M = 63;
  localparam int T0H_50M = 20;
  localparam int T1H_50M = 40;
  localparam int T_RST_50M = 2500;
  typedef enum logic [1:0] {GAP, LOAD, HIGH, LOW} state_t;
endpackage

// File: rtl/led_strip_driver_bit_timer.sv
// led_bit_timer: times the high and low phases of one serial bit and flags their ends.
module led_bit_timer import led_strip_driver_pkg::*; #(
  parameter int T_BIT = T_BIT_50M,
  parameter int T0H = T0H_50M,
  parameter int T1H = T1H_50M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic bit_val,
  output logic high_end,
  output logic bit_end
);
  localparam int W = $clog2(T_BIT);
  logic [W-1:0] cnt;
  always_comb begin
    high_end = run && cnt == W'(bit_val ? T1H - 1 : T0H - 1);
    bit_end = run && cnt == W'(T_BIT - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (run && !bit_end) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/led_strip_driver.sv
// led_strip_driver: streams 24-bit GRB colours for a chain of LEDs, one frame per latch gap.
module led_strip_driver import led_strip_driver_pkg::*; #(
  parameter int MAX_POS = 109,
  parameter int T_BIT = T_BIT_50M,
  parameter int T0H = T0H_50M,
  parameter int T1H = T1H_50M,
  parameter int T_RST = T_RST_50M
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic [$clog2(MAX_POS)-1:0] led_number,
  input  logic [7:0] green_intensity,
  input  logic [7:0] red_intensity,
  input  logic [7:0] blue_intensity,
  output logic data_out,
  output logic frame_done
);
  localparam int LW = $clog2(MAX_POS);
  localparam int GW = $clog2(T_RST);
  state_t state;
  logic [GW-1:0] gap_cnt;
  logic [23:0] shift;
  logic [4:0] bit_idx;
  logic high_end, bit_end;
  led_bit_timer #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H)) timer (
    .clk(clk),
    .rst_n(rst_n),
    .run(state == HIGH || state == LOW),
    .bit_val(shift[23]),
    .high_end(high_end),
    .bit_end(bit_end)
  );
  // data_out is registered alongside the state so it is high exactly in HIGH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GAP;
      gap_cnt <= '0;
      led_number <= '0;
      data_out <= 1'b0;
      frame_done <= 1'b0;
      shift <= '0;
      bit_idx <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        GAP: begin
          gap_cnt <= gap_cnt == GW'(T_RST - 1) ? '0 : gap_cnt + 1'b1;
          if (gap_cnt == GW'(T_RST - 1) && enable) state <= LOAD;
        end
        LOAD: begin
          shift <= {green_intensity, red_intensity, blue_intensity};
          bit_idx <= 5'd23;
          data_out <= 1'b1;
          state <= HIGH;
        end
        HIGH: if (high_end) begin
          data_out <= 1'b0;
          state <= LOW;
        end
        LOW: if (bit_end) begin
          if (bit_idx != '0) begin
            shift <= {shift[22:0], 1'b0};
            bit_idx <= bit_idx - 1'b1;
            data_out <= 1'b1;
            state <= HIGH;
          end else if (led_number == LW'(MAX_POS - 1)) begin
            led_number <= '0;
            frame_done <= 1'b1;
            state <= GAP;
          end else begin
            led_number <= led_number + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= GAP;
      endcase
    end
  end
endmodule

// File: tb/tb_led_strip_driver.sv
// tb_led_strip_driver: random-colour frames checked cycle by cycle against an arithmetic waveform model.
module tb_led_strip_driver;
  localparam int MP = 3, TB = 10, T0 = 3, T1 = 6, TR = 20, LEDC = 24 * TB + 1;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
  logic [7:0] green_intensity, red_intensity, blue_intensity;
  logic [1:0] led_number;
  logic data_out, frame_done;
  int checks = 0, failures = 0;
  int t, gap_t, frame_no, cyc, load_cycle, rst_hold, idle;
  bit in_frame, fd_next;
  logic [23:0] col [MP];

  led_strip_driver #(.MAX_POS(MP), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RST(TR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .led_number(led_number),
    .green_intensity(green_intensity),
    .red_intensity(red_intensity),
    .blue_intensity(blue_intensity),
    .data_out(data_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Line level at offset tt from the first LOAD: LOAD cycle, then 24 bits of TB cycles each
  function automatic logic exp_data(input int tt);
    int r, b, ph;
    logic [23:0] c;
    r = tt % LEDC;
    if (r == 0) return 1'b0;
    b = (r - 1) / TB;
    ph = (r - 1) % TB;
    c = col[tt / LEDC];
    return ph < (c[23 - b] ? T1 : T0);
  endfunction

  task automatic new_colours();
    frame_no++;
    for (int i = 0; i < MP; i++) col[i] = (frame_no == 1) ? 24'h800001 : 24'($urandom);
  endtask

  initial begin
    {green_intensity, red_intensity, blue_intensity} = '0;
    in_frame = 0; fd_next = 0; gap_t = 0; t = 0;
    frame_no = 0; cyc = 0; load_cycle = 0; rst_hold = 3; idle = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_data", data_out, 0);
        check("rst_led", led_number, 0);
        check("rst_done", frame_done, 0);
      end else if (in_frame) begin
        check("data", data_out, exp_data(t));
        check("led", led_number, t / LEDC);
        check("done", frame_done, 0);
      end else begin
        check("gap_data", data_out, 0);
        check("gap_led", led_number, 0);
        check("gap_done", frame_done, fd_next);
      end
      if (rst_n && frame_done) check("frame_len", cyc - load_cycle, MP * LEDC);
      if (frame_no == 2 && in_frame && t == 300) enable = 1'b0;
      if (frame_no == 2 && !in_frame) begin
        idle++;
        if (idle == 65) enable = 1'b1;
      end
      if (frame_no == 3 && in_frame && t == 2 * LEDC + 1) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_data", data_out, 0);
        check("async_led", led_number, 0);
        check("async_done", frame_done, 0);
        in_frame = 0; gap_t = 0; fd_next = 0; rst_hold = 3;
      end else if (!rst_n) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end
      {green_intensity, red_intensity, blue_intensity} =
        (rst_n && in_frame && t % LEDC == 0) ? col[t / LEDC] : 24'($urandom);
      if (rst_n) begin
        if (in_frame) begin
          if (t == MP * LEDC - 1) begin
            in_frame = 0; gap_t = 0; fd_next = 1;
          end else t++;
        end else begin
          fd_next = 0;
          if (gap_t == TR - 1) begin
            gap_t = 0;
            if (enable) begin
              in_frame = 1; t = 0; load_cycle = cyc + 1;
              new_colours();
            end
          end else gap_t++;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
